// File: rtl/hazard_pkg.sv
// Shared types and defaults for the pipeline hazard unit.
package hazard_pkg;

    localparam int REG_AW_DEF = 5;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } hz_state_t;

endpackage

// File: rtl/hazard_if.sv
// Hazard-unit bundle: pipeline status in, pipeline-register controls out.
// The master modport is the pipeline side; the slave modport is the hazard unit.
interface hazard_if #(
    parameter int REG_AW = 5
);
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_uses_rs1;
    logic              id_uses_rs2;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_mem_read;
    logic              ex_branch_taken;
    logic              mem_req;
    logic              mem_ready;
    logic              pc_write;
    logic              ifid_write;
    logic              idex_write;
    logic              exmem_write;
    logic              ifid_flush;
    logic              idex_flush;
    logic              mem_timeout;

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
               ex_branch_taken, mem_req, mem_ready,
        input  pc_write, ifid_write, idex_write, exmem_write,
               ifid_flush, idex_flush, mem_timeout
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
               ex_branch_taken, mem_req, mem_ready,
        output pc_write, ifid_write, idex_write, exmem_write,
               ifid_flush, idex_flush, mem_timeout
    );
endinterface

// File: rtl/hazard_perf_ctr.sv
// Saturating 32-bit event counter with synchronous active-low reset.
module hazard_perf_ctr (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    output logic [31:0] count
);
    logic [31:0] count_r;

    // Count one per cycle with inc high, holding at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_r <= 32'd0;
        end else if (inc && (count_r != 32'hFFFF_FFFF)) begin
            count_r <= count_r + 32'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;
endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: load-use bubbles, branch flushes, data-memory stalls
// with a timeout that halts the pipeline until reset.
// Optional build macro HAZARD_PERF_EN adds stall_cycles / flush_count outputs.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW  = REG_AW_DEF,
    parameter int TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        rst,
    hazard_if.slave     hz
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
`endif
);
    localparam int              CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    hz_state_t        state_r;
    hz_state_t        state_nxt_s;
    logic [CNT_W-1:0] wait_cnt_r;
    logic [CNT_W-1:0] wait_cnt_nxt_s;
    logic             mem_timeout_r;
    logic             mem_timeout_nxt_s;

    logic load_use_s;
    logic rs1_hit_s;
    logic rs2_hit_s;

    logic res_pc_write_s;
    logic res_ifid_write_s;
    logic res_ifid_flush_s;
    logic res_idex_flush_s;

    logic pc_write_s;
    logic ifid_write_s;
    logic idex_write_s;
    logic exmem_write_s;
    logic ifid_flush_s;
    logic idex_flush_s;

    // A load in EX whose non-zero destination feeds a live ID source operand.
    assign rs1_hit_s  = hz.id_uses_rs1 && (hz.id_rs1 == hz.ex_rd);
    assign rs2_hit_s  = hz.id_uses_rs2 && (hz.id_rs2 == hz.ex_rd);
    assign load_use_s = hz.ex_mem_read && (hz.ex_rd != {REG_AW{1'b0}})
                        && (rs1_hit_s || rs2_hit_s);

    // Branch/load-use resolution shared by RUN and the MEM_WAIT release cycle;
    // a taken branch squashes the dependent instruction, so load-use is ignored.
    always_comb begin
        res_pc_write_s   = 1'b1;
        res_ifid_write_s = 1'b1;
        res_ifid_flush_s = 1'b0;
        res_idex_flush_s = 1'b0;
        if (hz.ex_branch_taken) begin
            res_ifid_flush_s = 1'b1;
            res_idex_flush_s = 1'b1;
        end else if (load_use_s) begin
            res_pc_write_s   = 1'b0;
            res_ifid_write_s = 1'b0;
            res_idex_flush_s = 1'b1;
        end else begin
            res_pc_write_s   = 1'b1;
            res_ifid_write_s = 1'b1;
        end
    end

    // Control FSM: zero-latency outputs and next state/counter/halt flag.
    always_comb begin
        pc_write_s        = 1'b1;
        ifid_write_s      = 1'b1;
        idex_write_s      = 1'b1;
        exmem_write_s     = 1'b1;
        ifid_flush_s      = 1'b0;
        idex_flush_s      = 1'b0;
        state_nxt_s       = state_r;
        wait_cnt_nxt_s    = wait_cnt_r;
        mem_timeout_nxt_s = mem_timeout_r;
        case (state_r)
            RUN: begin
                if (hz.mem_req && !hz.mem_ready) begin
                    pc_write_s     = 1'b0;
                    ifid_write_s   = 1'b0;
                    idex_write_s   = 1'b0;
                    exmem_write_s  = 1'b0;
                    wait_cnt_nxt_s = CNT_ONE;
                    state_nxt_s    = MEM_WAIT;
                end else begin
                    pc_write_s     = res_pc_write_s;
                    ifid_write_s   = res_ifid_write_s;
                    ifid_flush_s   = res_ifid_flush_s;
                    idex_flush_s   = res_idex_flush_s;
                    wait_cnt_nxt_s = CNT_ZERO;
                end
            end
            MEM_WAIT: begin
                if (!hz.mem_ready) begin
                    pc_write_s    = 1'b0;
                    ifid_write_s  = 1'b0;
                    idex_write_s  = 1'b0;
                    exmem_write_s = 1'b0;
                    if (wait_cnt_r == TIMEOUT_C) begin
                        state_nxt_s       = HALT;
                        mem_timeout_nxt_s = 1'b1;
                    end else begin
                        wait_cnt_nxt_s = wait_cnt_r + CNT_ONE;
                    end
                end else begin
                    pc_write_s     = res_pc_write_s;
                    ifid_write_s   = res_ifid_write_s;
                    ifid_flush_s   = res_ifid_flush_s;
                    idex_flush_s   = res_idex_flush_s;
                    wait_cnt_nxt_s = CNT_ZERO;
                    state_nxt_s    = RUN;
                end
            end
            HALT: begin
                pc_write_s        = 1'b0;
                ifid_write_s      = 1'b0;
                idex_write_s      = 1'b0;
                exmem_write_s     = 1'b0;
                mem_timeout_nxt_s = 1'b1;
            end
            default: begin
                state_nxt_s    = RUN;
                wait_cnt_nxt_s = CNT_ZERO;
            end
        endcase
    end

    // State, wait counter and sticky timeout flag; reset abandons any wait.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r       <= RUN;
            wait_cnt_r    <= CNT_ZERO;
            mem_timeout_r <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            wait_cnt_r    <= wait_cnt_nxt_s;
            mem_timeout_r <= mem_timeout_nxt_s;
        end
    end

    assign hz.pc_write    = pc_write_s;
    assign hz.ifid_write  = ifid_write_s;
    assign hz.idex_write  = idex_write_s;
    assign hz.exmem_write = exmem_write_s;
    assign hz.ifid_flush  = ifid_flush_s;
    assign hz.idex_flush  = idex_flush_s;
    assign hz.mem_timeout = mem_timeout_r;

`ifdef HAZARD_PERF_EN
    hazard_perf_ctr u_stall_ctr (
        .clk   (clk),
        .rst   (rst),
        .inc   (!pc_write_s),
        .count (stall_cycles)
    );

    hazard_perf_ctr u_flush_ctr (
        .clk   (clk),
        .rst   (rst),
        .inc   (ifid_flush_s),
        .count (flush_count)
    );
`endif
endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit (TIMEOUT=4). Perf-counter checks are built
// only when HAZARD_PERF_EN is defined.
module tb_hazard_unit;
    import hazard_pkg::*;

    logic clk;
    logic rst;
    int   nvec;
    int   nerr;

    // Expected {pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_flush, mem_timeout}
    localparam logic [6:0] DEF   = 7'b1111_000;
    localparam logic [6:0] FRZ   = 7'b0000_000;
    localparam logic [6:0] HALTV = 7'b0000_001;
    localparam logic [6:0] BR    = 7'b1111_110;
    localparam logic [6:0] LU    = 7'b0011_010;

    hazard_if #(.REG_AW(5)) hz ();

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;
`endif

    hazard_unit #(.REG_AW(5), .TIMEOUT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .hz           (hz)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before 100000");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        hz.id_rs1          = 5'd0;
        hz.id_rs2          = 5'd0;
        hz.id_uses_rs1     = 1'b0;
        hz.id_uses_rs2     = 1'b0;
        hz.ex_rd           = 5'd0;
        hz.ex_mem_read     = 1'b0;
        hz.ex_branch_taken = 1'b0;
        hz.mem_req         = 1'b0;
        hz.mem_ready       = 1'b1;
    endtask

    task automatic check(input string tag, input logic [6:0] exp);
        logic [6:0] obs;
        #1;
        obs = {hz.pc_write, hz.ifid_write, hz.idex_write, hz.exmem_write,
               hz.ifid_flush, hz.idex_flush, hz.mem_timeout};
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        set_idle();
        rst = 1'b0;
        tick();
        check("reset_defaults", DEF);
        check_val("reset_wait_cnt", 32'(dut.wait_cnt_r), 32'd0);
        rst = 1'b1;

        // Load x5 in EX, ID reads rs1=x5: one bubble, then defaults.
        hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd5; hz.id_rs1 = 5'd5; hz.id_uses_rs1 = 1'b1;
        check("load_use_rs1", LU);
        tick();
        hz.ex_mem_read = 1'b0; hz.ex_rd = 5'd0;
        check("after_bubble", DEF);

        // x0 destination never stalls.
        hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd0; hz.id_rs1 = 5'd0; hz.id_uses_rs1 = 1'b1;
        check("x0_no_stall", DEF);
        tick();
        set_idle();
        hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd7; hz.id_rs2 = 5'd7; hz.id_uses_rs2 = 1'b1;
        check("load_use_rs2", LU);
        tick();
        hz.id_uses_rs2 = 1'b0;
        check("rs2_unused", DEF);
        tick();
        hz.id_uses_rs2 = 1'b1; hz.ex_mem_read = 1'b0;
        check("not_a_load", DEF);
        tick();
        hz.ex_mem_read = 1'b1; hz.ex_branch_taken = 1'b1;
        check("branch_over_load_use", BR);
        tick();
        set_idle();
        hz.ex_branch_taken = 1'b1;
        check("branch_only", BR);
        tick();

        // Fresh reset so perf counters start from zero.
        set_idle();
        rst = 1'b0;
        tick();
        rst = 1'b1;
`ifdef HAZARD_PERF_EN
        check_val("perf_reset_stall", stall_cycles, 32'd0);
        check_val("perf_reset_flush", flush_count, 32'd0);
`endif

        // Memory stall: 3 frozen cycles, release on the 4th.
        hz.mem_req = 1'b1; hz.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("mem_frozen_%0d", i), FRZ);
            tick();
        end
        hz.mem_ready = 1'b1;
        check("mem_release", DEF);
        tick();
        hz.mem_req = 1'b0;
`ifdef HAZARD_PERF_EN
        check_val("perf_stall_3", stall_cycles, 32'd3);
`endif

        // Stall outranks branch; release cycle applies the held branch.
        hz.mem_req = 1'b1; hz.mem_ready = 1'b0; hz.ex_branch_taken = 1'b1;
        check("mem_over_branch", FRZ);
        tick();
        check("wait_branch_held", FRZ);
        tick();
        hz.mem_ready = 1'b1;
        check("release_branch", BR);
        tick();
        set_idle();
`ifdef HAZARD_PERF_EN
        check_val("perf_stall_5", stall_cycles, 32'd5);
        check_val("perf_flush_1", flush_count, 32'd1);
`endif

        // Stall outranks load-use; release cycle applies the held load-use.
        hz.mem_req = 1'b1; hz.mem_ready = 1'b0;
        hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd3; hz.id_rs1 = 5'd3; hz.id_uses_rs1 = 1'b1;
        check("mem_over_load_use", FRZ);
        tick();
        hz.mem_ready = 1'b1;
        check("release_load_use", LU);
        tick();
        set_idle();

        // Reset mid-wait abandons it.
        hz.mem_req = 1'b1; hz.mem_ready = 1'b0;
        check("wait_before_reset", FRZ);
        tick();
        check("in_mem_wait", FRZ);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        set_idle();
        check("post_reset_defaults", DEF);
        check_val("post_reset_wait_cnt", 32'(dut.wait_cnt_r), 32'd0);
        tick();

        // Timeout: RUN stall cycle plus 4 wait cycles, then HALT.
        hz.mem_req = 1'b1; hz.mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("timeout_frozen_%0d", i), FRZ);
            tick();
        end
        check("halt_entered", HALTV);
        hz.mem_ready = 1'b1; hz.ex_branch_taken = 1'b1;
        tick();
        check("halt_sticky", HALTV);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        set_idle();
        check("halt_cleared", DEF);
        tick();
        check("run_after_halt", DEF);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 The block SHALL have parameter REG_AW, default 5, meaning register-index width.
REQ-002 The block SHALL have parameter TIMEOUT, default 256, meaning the maximum number of memory-wait cycles before a halt.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on posedge clk.
REQ-004 The block SHALL have port rst, input, 1; reset is synchronous and active-low.
REQ-005 The block SHALL have ports id_rs1/id_rs2, input, REG_AW, ID-stage source indices.
REQ-006 The block SHALL have ports id_uses_rs1/id_uses_rs2, input, 1, source-operand valid flags.
REQ-007 The block SHALL have port ex_rd, input, REG_AW, EX-stage destination index.
REQ-008 The block SHALL have port ex_mem_read, input, 1, EX instruction is a load.
REQ-009 The block SHALL have port ex_branch_taken, input, 1, redirect resolved in EX.
REQ-010 The block SHALL have ports mem_req/mem_ready, input, 1, data-memory access pending / completing.
REQ-011 The block SHALL have ports pc_write, ifid_write, idex_write, exmem_write, output, 1 each, driving the pipeline-register write enables.
REQ-012 The block SHALL have ports ifid_flush/idex_flush, output, 1, synchronous-clear requests to the IF/ID and ID/EX registers.
REQ-013 The block SHALL have port mem_timeout, output, 1, sticky halt flag.

Function
REQ-014 load_use SHALL equal ex_mem_read AND ex_rd!=0 AND ((id_uses_rs1 AND id_rs1==ex_rd) OR (id_uses_rs2 AND id_rs2==ex_rd)).
REQ-015 The FSM SHALL have states RUN, MEM_WAIT and HALT; all outputs SHALL be combinational from state and current inputs, with zero latency.
REQ-016 Default outputs SHALL be: all write enables 1, both flushes 0.
REQ-017 In RUN, priority SHALL be: memory stall > branch flush > load-use.
REQ-018 In RUN with mem_req=1 and mem_ready=0, all four write enables SHALL be 0 and both flushes 0, the wait counter SHALL load 1, and the next state SHALL be MEM_WAIT.
REQ-019 In RUN with no memory stall and ex_branch_taken=1, ifid_flush and idex_flush SHALL be 1 and pc_write 1; a load_use in the same cycle SHALL be ignored.
REQ-020 In RUN with load_use only, pc_write and ifid_write SHALL be 0, idex_flush 1, idex_write and exmem_write 1; this yields exactly one bubble.
REQ-021 In MEM_WAIT with mem_ready=0, all write enables SHALL be 0, flushes 0, and the wait counter SHALL increment.
REQ-022 In MEM_WAIT with mem_ready=1, the REQ-019/REQ-020 rules SHALL apply in the same cycle using the held ex_branch_taken/load_use, and the next state SHALL be RUN.
REQ-023 When the wait counter equals TIMEOUT and mem_ready=0, the next state SHALL be HALT and mem_timeout SHALL be set.
REQ-024 In HALT, all write enables SHALL be 0, flushes 0 and mem_timeout 1 until reset.
REQ-025 The wait counter SHALL be $clog2(TIMEOUT+1) bits wide and SHALL never wrap.

Reset
REQ-026 With rst=0 at posedge clk, the next state SHALL be RUN, the wait counter 0, mem_timeout 0, and the perf counters 0.
REQ-027 Reset asserted mid-MEM_WAIT or in HALT SHALL abandon the wait; the first post-reset cycle SHALL show default outputs.

Configuration
REQ-028 Macro HAZARD_PERF_EN SHALL control the performance counters.
REQ-029 With HAZARD_PERF_EN defined, the block SHALL add outputs stall_cycles[31:0] (+1 per cycle with pc_write=0) and flush_count[31:0] (+1 per cycle with ifid_flush=1), both saturating at 32'hFFFFFFFF.
REQ-030 Without HAZARD_PERF_EN, those ports and their logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-031 Package hazard_pkg SHALL hold the enum hz_state_t {RUN, MEM_WAIT, HALT} and localparam REG_AW_DEF=5.
REQ-032 The block SHALL contain one sub-module, hazard_perf_ctr (saturating 32-bit counter), instantiated twice under HAZARD_PERF_EN.

Verification
REQ-033 Load x5 in EX with ID add reading rs1=x5 -> one cycle of pc_write=0, ifid_write=0, idex_flush=1; the next cycle shows defaults.
REQ-034 ex_rd=0 with ex_mem_read=1 and id_rs1=0 -> no stall.
REQ-035 Branch taken and load_use in the same cycle -> ifid_flush=idex_flush=1 and pc_write=1.
REQ-036 mem_req=1 with mem_ready low for 3 cycles -> 3 frozen cycles, release on the 4th, and stall_cycles=3.
REQ-037 mem_ready held low with TIMEOUT=4 -> HALT after 4 wait cycles with mem_timeout=1; rst=0 for one cycle then returns to RUN with mem_timeout=0.
REQ-038 Reset asserted during MEM_WAIT -> defaults on the next cycle and the wait counter reads 0.
